dac_mc_driver: RTL

DAC_MC_DRIVER -- requirements
Module: dac_mc_driver

---
 rtl/dac_mc_driver.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/dac_mc_driver.sv
// ---------------------------------------------------------------------------
// dac_mc_driver
// Multi-channel DAC write sequencer. Each channel raises a request level;
// every rising edge captures that channel's target code. A round-robin
// arbiter grants one channel at a time, issues a one-cycle write strobe with
// the code and channel address, then waits a programmable settle time before
// flagging the channel done with a sticky ack.
//
// Optional build macro: DAC_DRIVER_RAMP_EN
//   When defined, each channel remembers the last code written and, with a
//   non-zero reg_ramp_step, approaches its target in steps of at most
//   reg_ramp_step, one write per settle period. Ack is raised only after the
//   final (target) write.
//
// Ports
//   clk            clock, rising edge
//   rst            asynchronous active-high reset
//   dac_req[NCH]   request levels (rising edge = new request)
//   dac_val        target codes, channel k at [k*DW +: DW]
//   ack_clr[NCH]   clear for the sticky acks
//   reg_dac_time   settle time in cycles per write (0 behaves as 1)
//   reg_ramp_step  ramp step size (ramp build only)
//   dac_data       registered DAC code
//   dac_sel        channel address for dac_data
//   dac_wr         one-cycle write strobe aligned with dac_data/dac_sel
//   dac_ack[NCH]   sticky per-channel done flags
//   busy           high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module dac_mc_driver #(
  parameter int DW  = 14,
  parameter int NCH = 4,
  parameter int CW  = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    dac_req,
  input  logic [NCH*DW-1:0] dac_val,
  input  logic [NCH-1:0]    ack_clr,
  input  logic [31:0]       reg_dac_time,
  input  logic [DW-1:0]     reg_ramp_step,
  output logic [DW-1:0]     dac_data,
  output logic [CW-1:0]     dac_sel,
  output logic              dac_wr,
  output logic [NCH-1:0]    dac_ack,
  output logic              busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;

  // Request synchronisers and edge detect.
  logic [NCH-1:0] sync1, sync2, sync3, armed, rise;
  logic [1:0]     warm_cnt;

  // A channel is armed only once its synchronised level has been seen low
  // after reset, so a level already high at reset release never counts as
  // a new request. warm_cnt waits until the synchroniser carries real data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= '0;
      sync2    <= '0;
      sync3    <= '0;
      armed    <= '0;
      rise     <= '0;
      warm_cnt <= 2'd0;
    end else begin
      sync1 <= dac_req;
      sync2 <= sync1;
      sync3 <= sync2;
      if (warm_cnt != 2'd2) warm_cnt <= warm_cnt + 2'd1;
      if (warm_cnt == 2'd2) armed <= armed | ~sync2;
      rise <= sync2 & ~sync3 & armed;
    end
  end

  logic [1:0]    state, state_next;
  logic [CW-1:0] cur, cur_next, rr_ptr, rr_next, grant, sel_next, cur_inc;
  logic          grant_ok, wr_next, finish, more_steps;
  logic [31:0]   cnt, cnt_next, thr;
  logic [NCH-1:0] pend, pend_clr, ack_set;
  logic [DW-1:0] data_next, code_grant, code_cur;
  logic [DW-1:0] val_lock [NCH];

  // Settle threshold, sampled live every cycle.
  assign thr     = (reg_dac_time == 32'd0) ? 32'd0 : reg_dac_time - 32'd1;
  assign cur_inc = (int'(cur) == NCH-1) ? '0 : cur + CW'(1);
  assign busy    = (state != IDLE);

  // First pending channel at or after rr_ptr; scanning downwards lets the
  // smallest offset win.
  always_comb begin
    grant_ok = 1'b0;
    grant    = '0;
    for (int i = NCH-1; i >= 0; i--) begin
      if (pend[(int'(rr_ptr) + i) % NCH]) begin
        grant_ok = 1'b1;
        grant    = CW'((int'(rr_ptr) + i) % NCH);
      end
    end
  end

`ifdef DAC_DRIVER_RAMP_EN
  logic [DW-1:0] last [NCH];

  function automatic logic [DW-1:0] step_code(input logic [DW-1:0] tgt,
                                              input logic [DW-1:0] from,
                                              input logic [DW-1:0] step);
    if (step == '0)     return tgt;
    if (tgt >= from)    return (tgt - from <= step) ? tgt : from + step;
    return (from - tgt <= step) ? tgt : from - step;
  endfunction

  assign code_grant = step_code(val_lock[grant], last[grant], reg_ramp_step);
  assign code_cur   = step_code(val_lock[cur], last[cur], reg_ramp_step);
  // Compared against the live target so an overwrite retargets the ramp.
  assign more_steps = (reg_ramp_step != '0) && (last[cur] != val_lock[cur]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NCH; k++) last[k] <= '0;
    end else if (wr_next) begin
      last[sel_next] <= data_next;
    end
  end
`else
  logic unused_ramp_step;
  assign unused_ramp_step = ^reg_ramp_step;
  assign code_grant = val_lock[grant];
  assign code_cur   = val_lock[cur];
  assign more_steps = 1'b0;
`endif

  // With a threshold of zero the write completes in LOAD itself, giving the
  // two-cycle spacing for the shortest settle times.
  assign finish = ((state == LOAD) && (thr == 32'd0)) ||
                  ((state == SETTLE) && (cnt >= thr));

  always_comb begin
    state_next = state;
    cur_next   = cur;
    cnt_next   = cnt;
    rr_next    = rr_ptr;
    data_next  = dac_data;
    sel_next   = dac_sel;
    wr_next    = 1'b0;
    pend_clr   = '0;
    ack_set    = '0;
    case (state)
      IDLE: begin
        if (grant_ok) begin
          // Pend moves into service here, so a rise during service
          // re-queues the channel.
          pend_clr[grant] = 1'b1;
          cur_next   = grant;
          data_next  = code_grant;
          sel_next   = grant;
          wr_next    = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        cnt_next = 32'd1;
        if (!finish) state_next = SETTLE;
      end
      SETTLE: begin
        if (!finish) cnt_next = cnt + 32'd1;
      end
      default: state_next = IDLE;
    endcase
    if (finish) begin
      if (more_steps) begin
        data_next  = code_cur;
        sel_next   = cur;
        wr_next    = 1'b1;
        state_next = LOAD;
      end else begin
        ack_set[cur] = 1'b1;
        rr_next      = cur_inc;
        state_next   = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cur      <= '0;
      cnt      <= 32'd0;
      rr_ptr   <= '0;
      pend     <= '0;
      dac_data <= '0;
      dac_sel  <= '0;
      dac_wr   <= 1'b0;
      dac_ack  <= '0;
      for (int k = 0; k < NCH; k++) val_lock[k] <= '0;
    end else begin
      state    <= state_next;
      cur      <= cur_next;
      cnt      <= cnt_next;
      rr_ptr   <= rr_next;
      pend     <= (pend & ~pend_clr) | rise;
      dac_data <= data_next;
      dac_sel  <= sel_next;
      dac_wr   <= wr_next;
      // Completion wins over a simultaneous clear.
      dac_ack  <= (dac_ack & ~ack_clr) | ack_set;
      for (int k = 0; k < NCH; k++) begin
        if (rise[k]) val_lock[k] <= dac_val[k*DW +: DW];
      end
    end
  end

endmodule
